// File: rtl/otter_timer_counter.sv
`timescale 1ns/1ps
// otter_timer_counter: memory-mapped prescaled up-counter with compare,
// auto-reload and a one-cycle interrupt pulse for the OTTER MCU I/O bus.
//
// Register map (byte offsets from BASE_ADDR, exact 32-bit decode):
//   0x0 CSR      bit0 EN, bit1 AUTO, bit2 IE, bit8 EXP (sticky, W1C)
//   0x4 PRESCALE 16 bits, a write also clears the prescaler counter
//   0x8 TC       32-bit terminal count
//   0xC COUNT    read-only current count
//
// Bus handshake: iobus_wr is a single-cycle strobe; the addressed register
// takes iobus_out on the rising edge where iobus_wr=1. There is no
// back-pressure. iobus_in is a purely combinational read of the register
// selected by iobus_addr, so reads have zero latency.
//
// Counting: while the FSM is RUN or FIRE and EN=1, the prescaler counts
// 0..PRESCALE and emits a tick on PRESCALE. A tick with COUNT>=TC is an
// expiry (COUNT clears, EXP sets, EN clears unless AUTO); otherwise COUNT
// increments. A CSR write that clears EN blocks the increment on a
// coincident tick, but an expiry on that tick is still recorded so that a
// W1C of EXP racing an expiry cannot lose the event.
module otter_timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h1120_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_in,
  output logic        intr,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] ADDR_CSR   = BASE_ADDR;
  localparam logic [31:0] ADDR_PRE   = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_TC    = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_COUNT = BASE_ADDR + 32'hC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIRE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        csr_en;
  logic        csr_auto;
  logic        csr_ie;
  logic        csr_exp;
  logic [15:0] prescale;
  logic [31:0] tc;
  logic [31:0] count;
  logic [15:0] pcnt;

  logic        sel_csr;
  logic        sel_pre;
  logic        sel_tc;
  logic        sel_count;
  logic        wr_csr;
  logic        wr_pre;
  logic        wr_tc;
  logic        en_write;
  logic        running;
  logic        tick;
  logic        expire;
  logic        incr;

  // Address decode: exact match only, so aliases and neighbours are inert.
  always_comb begin
    sel_csr   = (iobus_addr == ADDR_CSR);
    sel_pre   = (iobus_addr == ADDR_PRE);
    sel_tc    = (iobus_addr == ADDR_TC);
    sel_count = (iobus_addr == ADDR_COUNT);
    wr_csr    = iobus_wr && sel_csr;
    wr_pre    = iobus_wr && sel_pre;
    wr_tc     = iobus_wr && sel_tc;
  end

  // Tick / expiry qualification for the current cycle.
  always_comb begin
    // EN as software wants it after this cycle's bus write.
    en_write = wr_csr ? iobus_out[0] : csr_en;
    running  = (state != S_IDLE) && csr_en;
    tick     = running && (pcnt == prescale);
    // >= so that lowering TC under COUNT expires on the next tick.
    expire   = tick && (count >= tc);
    incr     = tick && !expire && en_write;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; FIRE lasts one cycle unless another expiry lands.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (csr_en) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (expire) begin
          state_next = S_FIRE;
        end else if (!csr_en) begin
          state_next = S_IDLE;
        end
      end
      S_FIRE: begin
        if (expire) begin
          state_next = S_FIRE;
        end else if (csr_en) begin
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // CSR fields: software write, then hardware expiry overrides EN and EXP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_en   <= 1'b0;
      csr_auto <= 1'b0;
      csr_ie   <= 1'b0;
      csr_exp  <= 1'b0;
    end else begin
      if (wr_csr) begin
        csr_auto <= iobus_out[1];
        csr_ie   <= iobus_out[2];
      end
      if (expire && !csr_auto) begin
        csr_en <= 1'b0;
      end else begin
        csr_en <= en_write;
      end
      if (expire) begin
        csr_exp <= 1'b1;
      end else if (wr_csr && iobus_out[8]) begin
        csr_exp <= 1'b0;
      end
    end
  end

  // PRESCALE and TC software registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= 16'd0;
      tc       <= 32'd0;
    end else begin
      if (wr_pre) begin
        prescale <= iobus_out[15:0];
      end
      if (wr_tc) begin
        tc <= iobus_out;
      end
    end
  end

  // Prescaler counter: restarts on a PRESCALE write, holds while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= 16'd0;
    end else if (wr_pre) begin
      pcnt <= 16'd0;
    end else if (running) begin
      if (tick) begin
        pcnt <= 16'd0;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
    end
  end

  // Main count: clears on expiry, increments on an ordinary tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 32'd0;
    end else if (expire) begin
      count <= 32'd0;
    end else if (incr) begin
      count <= count + 32'd1;
    end
  end

  // Interrupt pulse, registered alongside the transition into FIRE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intr <= 1'b0;
    end else begin
      intr <= expire && csr_ie;
    end
  end

  // Zero-latency read mux; unmapped addresses read as 0.
  always_comb begin
    iobus_in = 32'd0;
    if (sel_csr) begin
      iobus_in = {23'd0, csr_exp, 5'd0, csr_ie, csr_auto, csr_en};
    end else if (sel_pre) begin
      iobus_in = {16'd0, prescale};
    end else if (sel_tc) begin
      iobus_in = tc;
    end else if (sel_count) begin
      iobus_in = count;
    end
  end

endmodule
